fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the P7 pipelined MIPS core.
- Owns the PC register and drives the instruction-memory address; the memory returns the instruction combinationally in the same cycle.
- Checks the fetch address for AdEL and captures instruction, PC, exception code and delay-slot flag into the F/D pipeline register.
- Handles stall, branch/jump redirect from D, exception entry and ERET return from CP0.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, instruction-memory depth in words. Legal range is IM_BASE .. IM_BASE+4*IM_WORDS-4.
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry PC.

Ports:
- clk, input, 1, core clock. All state updates on the rising edge.
- reset, input, 1, asynchronous, active-low. Low forces every register to its reset value immediately.
- stall, input, 1, hazard-unit stall. Holds PC and F/D.
- br_taken, input, 1, D-stage branch/jump redirect valid.
- br_target, input, 32, D-stage redirect target.
- is_branch_d, input, 1, the instruction currently in D is a branch/jump, so the instruction being fetched is its delay slot.
- req, input, 1, CP0 exception/interrupt request. Flushes F/D.
- eret, input, 1, ERET in D. Redirect to epc and flush F/D.
- epc, input, 32, CP0 EPC value.
- im_addr, output, 32, fetch address to instruction memory. Equals the current PC.
- im_instr, input, 32, instruction word from instruction memory.
- pc_f, output, 32, current PC, for macroscopic-PC observation.
- instr_d, output, 32, F/D instruction.
- pc_d, output, 32, F/D PC.
- exccode_d, output, 5, F/D exception code. 0 means none; 4 means AdEL.
- bd_d, output, 1, F/D branch-delay flag.

Behaviour:
- Reset (reset low, asynchronous):
  - pc = PC_RESET.
  - instr_d = 0.
  - pc_d = PC_RESET.
  - exccode_d = 0.
  - bd_d = 0.
- After reset deasserts, the first edge fetches PC_RESET.
- Combinational:
  - im_addr = pc_f = pc.
  - adel_f = (pc[1:0] != 0) OR (pc < IM_BASE) OR (pc > IM_BASE + 4*IM_WORDS - 4). Compare as unsigned 32-bit.
  - instr_f = adel_f ? 0 : im_instr. An illegal address is never passed downstream.
  - exc_f = adel_f ? 5'd4 : 5'd0.
- Next-PC priority, evaluated every edge (first match wins):
  1. req: pc <= EXC_ENTRY.
  2. eret: pc <= epc.
  3. stall: pc holds.
  4. br_taken: pc <= br_target.
  5. otherwise: pc <= pc + 4. 32-bit wrap; wrap-around produces AdEL on the next fetch.
- br_taken during stall is ignored. D holds and re-presents the redirect on the next unstalled cycle.
- F/D register update (same priority):
  - req or eret (flush): instr_d <= 0, exccode_d <= 0, bd_d <= 0, pc_d <= the new pc value (EXC_ENTRY or epc). The bubble carries a meaningful PC for CP0.
  - stall: all F/D outputs hold.
  - otherwise: instr_d <= instr_f, pc_d <= pc, exccode_d <= exc_f, bd_d <= is_branch_d.
- Simultaneous events:
  - req with eret: req wins.
  - req with stall: req wins; PC and F/D still redirect/flush.
  - eret with stall: eret wins.
- Latency: an instruction appears on the F/D outputs one edge after its PC is presented on im_addr.
- Branch delay slot: the instruction after a branch is always fetched. br_taken redirects the PC from the edge after the delay-slot fetch is captured.
- epc misaligned: handled as an ordinary AdEL on the next fetch; no special case.

Decomposition:
- Shared package (cpu_defs):
  - PC_RESET and EXC_ENTRY constants.
  - EXC_ADEL = 5'd4 and EXC_NONE = 5'd0.
  - NOP = 32'h0000_0000.
  - Same IM_BASE/IM_WORDS values as the instruction memory.
- One combinational sub-module, fetch_addr_check: takes pc and produces adel_f. Reused by any later data-side address checker.
- PC register and F/D register stay inline.

Test Plan:
- Reset held low mid-run, then released → pc_f = 32'h3000 immediately. After 3 free edges (no stall/branch), pc_f = 32'h300C and pc_d = 32'h3008 with instr_d = im_instr for 0x3008.
- stall high 2 cycles at pc 32'h3010 → pc_f stays 32'h3010; instr_d/pc_d unchanged for both edges; normal advance resumes after.
- is_branch_d=1 and br_taken=1 with br_target=32'h3100 while pc=32'h3024 → next edge: pc_d=32'h3024, bd_d=1, pc_f=32'h3100.
- br_target=32'h3102 → following edge: instr_d=0, exccode_d=4, pc_d=32'h3102. With br_target=32'h7000 → exccode_d=4, pc_d=32'h7000.
- req with stall and br_taken all high → next edge: pc_f=32'h4180, instr_d=0, exccode_d=0, bd_d=0, pc_d=32'h4180.
- eret with epc=32'h3040 (req low) → pc_f=32'h3040, F/D bubble with pc_d=32'h3040. Then req and eret together → pc_f=32'h4180.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the P7 pipelined MIPS core.
// Holds the reset/exception PCs, the instruction-memory window and the
// exception codes used when building the F/D pipeline register.
package cpu_defs;

    // PC value loaded by reset
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    // Exception / interrupt handler entry point
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

    // Instruction-memory window (must match the instruction memory itself)
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam int unsigned IM_WORDS  = 4096;
    // Highest legal word address: IM_BASE + 4*IM_WORDS - 4
    localparam logic [31:0] IM_LAST   = IM_BASE + 32'(IM_WORDS * 4) - 32'd4;

    // Exception codes carried down the pipe
    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    // Bubble instruction (sll $0,$0,0)
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // True when a byte address is word aligned
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : cpu_defs

// File: rtl/fetch_addr_check.sv
// Address-error check for a word fetch.
// Flags an address that is misaligned or falls outside the window
// [LO_ADDR, HI_ADDR] (unsigned compare). Purely combinational so it can be
// reused by a data-side checker with a different window.
// Ports:
//   pc   - byte address being fetched
//   adel - 1 when the fetch must raise an address-error-on-load exception
module fetch_addr_check
    import cpu_defs::*;
#(
    parameter logic [31:0] LO_ADDR = IM_BASE,
    parameter logic [31:0] HI_ADDR = IM_LAST
) (
    input  logic [31:0] pc,
    output logic        adel
);

    logic misaligned_s;
    logic below_s;
    logic above_s;

    // Classify the address against alignment and window bounds
    always_comb begin
        misaligned_s = !is_word_aligned(pc);
        below_s      = (pc < LO_ADDR);
        above_s      = (pc > HI_ADDR);
        adel         = misaligned_s | below_s | above_s;
    end

endmodule : fetch_addr_check

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the P7 pipelined MIPS core.
// Owns the PC, drives the instruction-memory address (memory answers in the
// same cycle), checks the fetch for AdEL and loads the F/D pipeline register.
// Redirect priority on every edge: req > eret > stall > br_taken > pc+4.
// Ports:
//   clk, reset (async, active-low)
//   stall        - hold PC and F/D
//   br_taken / br_target / is_branch_d - D-stage redirect and delay-slot flag
//   req, eret, epc - CP0 exception entry and return
//   im_addr / im_instr - instruction-memory interface
//   pc_f         - current PC
//   instr_d, pc_d, exccode_d, bd_d - F/D register outputs
module fetch_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        is_branch_d,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [4:0]  exccode_d,
    output logic        bd_d
);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic        adel_f_s;
    logic [31:0] instr_f_s;
    logic [4:0]  exc_f_s;
    logic        flush_s;

    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [4:0]  exccode_d_r;
    logic        bd_d_r;

    fetch_addr_check #(
        .LO_ADDR (IM_BASE),
        .HI_ADDR (IM_LAST)
    ) u_addr_check (
        .pc   (pc_r),
        .adel (adel_f_s)
    );

    // Squash illegal fetches so a bad address never reaches decode
    always_comb begin
        instr_f_s = im_instr;
        exc_f_s   = EXC_NONE;
        if (adel_f_s) begin
            instr_f_s = NOP;
            exc_f_s   = EXC_ADEL;
        end else begin
            instr_f_s = im_instr;
            exc_f_s   = EXC_NONE;
        end
    end

    // Next-PC selection; a stalled redirect is re-presented by D later
    always_comb begin
        pc_next_s = pc_r + 32'd4;
        flush_s   = req | eret;
        if (req) begin
            pc_next_s = EXC_ENTRY;
        end else if (eret) begin
            pc_next_s = epc;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else if (br_taken) begin
            pc_next_s = br_target;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= PC_RESET;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // F/D register; a flush bubble carries the redirect PC so CP0 sees a
    // meaningful PC even for an empty slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_d_r   <= NOP;
            pc_d_r      <= PC_RESET;
            exccode_d_r <= EXC_NONE;
            bd_d_r      <= 1'b0;
        end else if (flush_s) begin
            instr_d_r   <= NOP;
            pc_d_r      <= pc_next_s;
            exccode_d_r <= EXC_NONE;
            bd_d_r      <= 1'b0;
        end else if (!stall) begin
            instr_d_r   <= instr_f_s;
            pc_d_r      <= pc_r;
            exccode_d_r <= exc_f_s;
            bd_d_r      <= is_branch_d;
        end else begin
            instr_d_r   <= instr_d_r;
            pc_d_r      <= pc_d_r;
            exccode_d_r <= exccode_d_r;
            bd_d_r      <= bd_d_r;
        end
    end

    assign im_addr   = pc_r;
    assign pc_f      = pc_r;
    assign instr_d   = instr_d_r;
    assign pc_d      = pc_d_r;
    assign exccode_d = exccode_d_r;
    assign bd_d      = bd_d_r;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected post-edge
// state computed by a behavioural model; a monitor pops and compares it
// one time unit after every rising edge.
module tb_fetch_unit;

    localparam logic [31:0] T_RESET = 32'h0000_3000;
    localparam logic [31:0] T_EXC   = 32'h0000_4180;
    localparam logic [31:0] T_LO    = 32'h0000_3000;
    localparam logic [31:0] T_HI    = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        is_branch_d = 1'b0;
    logic        req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'd0;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [4:0]  exccode_d;
    logic        bd_d;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t m;          // model state: pc plus F/D contents

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .is_branch_d(is_branch_d), .req(req),
        .eret(eret), .epc(epc), .im_addr(im_addr), .im_instr(im_instr),
        .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .exccode_d(exccode_d),
        .bd_d(bd_d)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a non-zero word derived from the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign im_instr = mem_word(im_addr);

    function automatic logic legal(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && (a >= T_LO) && (a <= T_HI);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT against the oldest expectation after each edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk("sb_pc_f",   pc_f,             x.pc);
                chk("sb_im_addr", im_addr,         x.pc);
                chk("sb_instr_d", instr_d,         x.instr);
                chk("sb_pc_d",   pc_d,             x.pcd);
                chk("sb_exccode", {27'd0, exccode_d}, {27'd0, x.exc});
                chk("sb_bd_d",   {31'd0, bd_d},    {31'd0, x.bd});
            end
        end
    end

    // One clock of stimulus; model decides the outcome from the rules
    task automatic step(input logic s, input logic b, input logic [31:0] t,
                        input logic isb, input logic r, input logic e,
                        input logic [31:0] ep);
        exp_t n;
        stall = s; br_taken = b; br_target = t; is_branch_d = isb;
        req = r; eret = e; epc = ep;
        n = m;
        if (r || e) begin
            n.pc    = r ? T_EXC : ep;
            n.instr = 32'd0;
            n.exc   = 5'd0;
            n.bd    = 1'b0;
            n.pcd   = n.pc;
        end else if (!s) begin
            n.instr = legal(m.pc) ? mem_word(m.pc) : 32'd0;
            n.exc   = legal(m.pc) ? 5'd0 : 5'd4;
            n.pcd   = m.pc;
            n.bd    = isb;
            n.pc    = b ? t : m.pc + 32'd4;
        end
        m = n;
        sb_q.push_back(n);
        @(negedge clk);
    endtask

    task automatic free_step();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Asynchronous reset mid-cycle, held across an edge, released at negedge
    task automatic do_reset();
        stall = 1'b0; br_taken = 1'b0; is_branch_d = 1'b0; req = 1'b0; eret = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_pc_f",    pc_f,    T_RESET);
        chk("rst_instr_d", instr_d, 32'd0);
        chk("rst_pc_d",    pc_d,    T_RESET);
        chk("rst_exc_bd",  {26'd0, exccode_d, bd_d}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m.pc = T_RESET; m.instr = 32'd0; m.pcd = T_RESET; m.exc = 5'd0; m.bd = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6) return T_LO + ($urandom_range(0, 4095) * 32'd4);
        else if (k == 6) return T_LO + $urandom_range(0, 16383);
        else if (k == 7) return T_HI - 32'd4 * $urandom_range(0, 2);
        else if (k == 8) return 32'hFFFF_FFF8;
        else return $urandom();
    endfunction

    initial begin
        m = '0;
        @(negedge clk);
        do_reset();

        // Three free edges from reset
        repeat (3) free_step();
        chk("tp_pc_f_300c",  pc_f,    32'h0000_300C);
        chk("tp_pc_d_3008",  pc_d,    32'h0000_3008);
        chk("tp_instr_3008", instr_d, mem_word(32'h0000_3008));

        // Stall two cycles at 0x3010
        free_step();
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_3500, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("tp_stall_pc", pc_f, 32'h0000_3010);
        chk("tp_stall_pcd", pc_d, 32'h0000_300C);
        free_step();

        // Branch with delay-slot flag at 0x3024
        while (m.pc != 32'h0000_3024) free_step();
        step(1'b0, 1'b1, 32'h0000_3100, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("tp_br_pcd", pc_d, 32'h0000_3024);
        chk("tp_br_bd",  {31'd0, bd_d}, 32'd1);
        chk("tp_br_pc",  pc_f, 32'h0000_3100);

        // Misaligned and out-of-window targets
        step(1'b0, 1'b1, 32'h0000_3102, 1'b0, 1'b0, 1'b0, 32'd0);
        free_step();
        chk("tp_mis_exc", {27'd0, exccode_d}, 32'd4);
        chk("tp_mis_pcd", pc_d, 32'h0000_3102);
        step(1'b0, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b0, 32'd0);
        free_step();
        chk("tp_oob_exc", {27'd0, exccode_d}, 32'd4);
        chk("tp_oob_pcd", pc_d, 32'h0000_7000);

        // Exception entry beats stall and branch
        step(1'b1, 1'b1, 32'h0000_3200, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("tp_req_pc",  pc_f, 32'h0000_4180);
        chk("tp_req_pcd", pc_d, 32'h0000_4180);

        // ERET, then req together with eret
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0000_3040);
        chk("tp_eret_pc", pc_f, 32'h0000_3040);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_3040);
        chk("tp_req_eret_pc", pc_f, 32'h0000_4180);

        // Wrap-around through 0xFFFFFFFC
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (3) free_step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, rand_target(),
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 5, rand_target());
        end

        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_unit
